// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table and shared types for the 7-segment scan display.
// Revision: 1.0 - initial release
`default_nettype none

package seg7_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Glyphs are active-high, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] hex_to_glyph(input logic [3:0] i_nib);
    logic [6:0] w_g;
    case (i_nib)
      4'h0:    w_g = 7'h3F;
      4'h1:    w_g = 7'h06;
      4'h2:    w_g = 7'h5B;
      4'h3:    w_g = 7'h4F;
      4'h4:    w_g = 7'h66;
      4'h5:    w_g = 7'h6D;
      4'h6:    w_g = 7'h7D;
      4'h7:    w_g = 7'h07;
      4'h8:    w_g = 7'h7F;
      4'h9:    w_g = 7'h6F;
      4'hA:    w_g = 7'h77;
      4'hB:    w_g = 7'h7C;
      4'hC:    w_g = 7'h39;
      4'hD:    w_g = 7'h5E;
      4'hE:    w_g = 7'h79;
      default: w_g = 7'h71;
    endcase
    return w_g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_display_bin2bcd.sv
// bin2bcd_seq: one double-dabble step per cycle with sticky overflow out of the top digit.
// Revision: 1.0 - initial release
`default_nettype none

module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [DATA_W-1:0]       i_bin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_ovf
);

  localparam int c_CNT_W = $clog2(DATA_W);

  logic                             r_busy;
  logic [c_CNT_W-1:0]               r_cnt;
  logic [DATA_W-1:0]                r_shift;
  bcd_digit_t [NUM_DIGITS-1:0]      r_bcd;
  logic                             r_ovf;
  bcd_digit_t [NUM_DIGITS-1:0]      w_adj;
  bcd_digit_t [NUM_DIGITS-1:0]      w_bcd_nxt;
  logic                             w_carry;
  logic                             w_last;

  assign w_last = (r_cnt == c_CNT_W'(DATA_W - 1));

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_bcd[d] >= 4'd5) w_adj[d] = r_bcd[d] + 4'd3;
    end
    {w_carry, w_bcd_nxt} = {w_adj, r_shift[DATA_W-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_shift <= i_bin;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
    end else if (i_abort) begin
      r_busy  <= 1'b0;
    end else if (r_busy) begin
      r_shift <= r_shift << 1;
      r_bcd   <= w_bcd_nxt;
      r_ovf   <= r_ovf | w_carry;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  // The final step's result is presented combinationally so the caller can latch it on the falling edge of busy
  assign o_busy = r_busy;
  assign o_done = r_busy & w_last & ~i_start & ~i_abort;
  assign o_bcd  = w_bcd_nxt;
  assign o_ovf  = r_ovf | w_carry;

endmodule

`default_nettype wire

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: captures a value, renders hex or decimal digits and time-multiplexes them onto the anodes.
// Revision: 1.0 - initial release
`default_nettype none

module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV   = 25000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  enable,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  busy,
  output logic                  overflow
);

  localparam int   c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   c_PRE_W = $clog2(SCAN_DIV);
  localparam int   c_BCD_W = 4 * NUM_DIGITS;
  localparam logic c_INV   = (ACTIVE_LOW != 0);

  logic [c_PRE_W-1:0]          r_presc;
  logic [c_IDX_W-1:0]          r_idx;
  bcd_digit_t [NUM_DIGITS-1:0] r_dig;
  logic                        r_ovf;
  logic [NUM_DIGITS-1:0]       r_an;
  logic [6:0]                  r_seg;
  logic                        r_dp;

  logic                        w_start;
  logic                        w_hex;
  logic                        w_busy;
  logic                        w_done;
  logic [c_BCD_W-1:0]          w_bcd;
  logic                        w_bcd_ovf;
  logic [c_BCD_W-1:0]          w_hex_dig;
  logic                        w_hex_ovf;
  logic                        w_wrap;
  logic [NUM_DIGITS-1:0]       w_zero_from;
  logic                        w_zero_acc;
  logic                        w_blank;
  logic [6:0]                  w_glyph;
  logic [NUM_DIGITS-1:0]       w_onehot;

  assign w_start = load & mode;
  assign w_hex   = load & ~mode;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_abort (w_hex),
    .i_bin   (value),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_ovf   (w_bcd_ovf)
  );

  generate
    if (DATA_W > c_BCD_W) begin : g_wide
      assign w_hex_dig = value[c_BCD_W-1:0];
      assign w_hex_ovf = |value[DATA_W-1:c_BCD_W];
    end else begin : g_narrow
      assign w_hex_dig = c_BCD_W'(value);
      assign w_hex_ovf = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dig <= '0;
      r_ovf <= 1'b0;
    end else if (w_hex) begin
      r_dig <= w_hex_dig;
      r_ovf <= w_hex_ovf;
    end else if (w_done) begin
      r_dig <= w_bcd;
      r_ovf <= w_bcd_ovf;
    end
  end

  // w_zero_from[i]: digits i..top are all zero
  always_comb begin
    w_zero_acc  = 1'b1;
    w_zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_acc     = w_zero_acc & (r_dig[i] == 4'd0);
      w_zero_from[i] = w_zero_acc;
    end
  end

  assign w_wrap   = (r_presc == c_PRE_W'(SCAN_DIV - 1));
  assign w_blank  = blank_lz & (r_idx != '0) & w_zero_from[r_idx];
  assign w_glyph  = r_ovf   ? SEG_DASH  :
                    w_blank ? SEG_BLANK : hex_to_glyph(r_dig[r_idx]);
  assign w_onehot = NUM_DIGITS'(1) << r_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= {NUM_DIGITS{c_INV}};
      r_seg   <= {7{c_INV}};
      r_dp    <= c_INV;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_wrap) begin
        r_idx <= (r_idx == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        r_seg <= w_glyph ^ {7{c_INV}};
        r_dp  <= dp_mask[r_idx] ^ c_INV;
      end
      if (!enable) begin
        r_an <= {NUM_DIGITS{c_INV}};
      end else if (w_wrap) begin
        r_an <= w_onehot ^ {NUM_DIGITS{c_INV}};
      end
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign dp       = r_dp;
  assign busy     = w_busy;
  assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: vector table plus directed sequences for the scan display (4 digits, SCAN_DIV=4, active-low).
// Revision: 1.0 - initial release
`default_nettype none

module tb_seg7_scan_display;

  localparam int ND  = 4;
  localparam int DW  = 16;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] value;
  logic          load;
  logic          mode;
  logic          blank_lz;
  logic [ND-1:0] dp_mask;
  logic          enable;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic          busy;
  logic          overflow;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [15:0]     val;
    logic            md;
    logic            blz;
    logic [3:0]      dpm;
    logic [3:0][6:0] eseg;
    logic            eovf;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];

  seg7_scan_display #(
    .NUM_DIGITS (ND),
    .DATA_W     (DW),
    .SCAN_DIV   (DIV),
    .ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .mode     (mode),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .enable   (enable),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_val(input logic [15:0] v, input logic m);
    @(negedge clk);
    value = v;
    mode  = m;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Watch one full scan round and compare each digit the moment its anode appears
  task automatic observe_round(input logic [3:0][6:0] eseg, input logic [3:0] dpm, input string tag);
    logic [3:0] prev_an;
    logic [3:0] act;
    logic [3:0] seen;
    int         prev_d;
    int         dwell;
    int         d;
    repeat (DIV + 1) @(negedge clk);
    prev_an = an;
    prev_d  = -1;
    dwell   = 0;
    seen    = '0;
    for (int c = 0; c < (ND + 1) * DIV; c++) begin
      @(negedge clk);
      dwell++;
      if (an !== prev_an) begin
        act = ~an;
        d   = -1;
        for (int i = 0; i < ND; i++) if (act == 4'(1 << i)) d = i;
        if (d < 0) begin
          check({tag, "_an_onehot"}, {28'd0, an}, 32'hFFFF_FFFF);
        end else begin
          check($sformatf("%s_seg%0d", tag, d), {25'd0, seg}, {25'd0, eseg[d]});
          check($sformatf("%s_dp%0d", tag, d), {31'd0, dp}, {31'd0, ~dpm[d]});
          if (prev_d >= 0) begin
            check({tag, "_order"}, d, (prev_d + 1) % ND);
            check({tag, "_dwell"}, dwell, DIV);
          end
          seen[d] = 1'b1;
        end
        prev_d  = d;
        prev_an = an;
        dwell   = 0;
      end
    end
    check({tag, "_all_digits"}, {28'd0, seen}, 32'hF);
  endtask

  initial begin : main
    int   n;
    int   bad;
    vec_t e;

    vecs[0]  = '{16'hA5C3, 1'b0, 1'b0, 4'b0000, {7'h08, 7'h12, 7'h46, 7'h30}, 1'b0};
    vecs[1]  = '{16'd1234, 1'b1, 1'b0, 4'b0001, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
    vecs[2]  = '{16'd12345, 1'b1, 1'b0, 4'b1010, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
    vecs[3]  = '{16'd7, 1'b1, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0};
    vecs[4]  = '{16'd0, 1'b1, 1'b1, 4'b0100, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
    vecs[5]  = '{16'h00F0, 1'b0, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h0E, 7'h40}, 1'b0};
    vecs[6]  = '{16'd9999, 1'b1, 1'b0, 4'b0000, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0};
    vecs[7]  = '{16'd10000, 1'b1, 1'b0, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
    vecs[8]  = '{16'h0BEF, 1'b0, 1'b0, 4'b1111, {7'h40, 7'h03, 7'h06, 7'h0E}, 1'b0};
    vecs[9]  = '{16'd65535, 1'b1, 1'b1, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
    vecs[10] = '{16'h8000, 1'b0, 1'b1, 4'b0000, {7'h00, 7'h40, 7'h40, 7'h40}, 1'b0};
    vecs[11] = '{16'd255, 1'b1, 1'b1, 4'b0000, {7'h7F, 7'h24, 7'h12, 7'h12}, 1'b0};

    reset = 1'b1; value = '0; load = 1'b0; mode = 1'b0;
    blank_lz = 1'b0; dp_mask = '0; enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Outputs stay inactive until the first scan edge
    for (int k = 0; k < DIV - 1; k++) begin
      @(negedge clk);
      check("rst_an", {28'd0, an}, 32'hF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_dp", {31'd0, dp}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
    end
    observe_round({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, "rst_zero");

    foreach (vecs[i]) begin
      blank_lz = vecs[i].blz;
      dp_mask  = vecs[i].dpm;
      load_val(vecs[i].val, vecs[i].md);
      sb.push_back(vecs[i]);
      wait_busy(n);
      e = sb.pop_front();
      check($sformatf("v%0d_busy_len", i), n, e.md ? DW : 0);
      check($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, e.eovf});
      observe_round(e.eseg, e.dpm, $sformatf("v%0d", i));
    end

    // Restart: second decimal load replaces the first, with no partial results on display
    blank_lz = 1'b0; dp_mask = '0;
    load_val(16'h0000, 1'b0);
    repeat (DIV * ND) @(negedge clk);
    load_val(16'd1234, 1'b1);
    bad = 0;
    repeat (3) begin
      if (an !== 4'hF && seg !== 7'h40) bad++;
      @(negedge clk);
    end
    load_val(16'd42, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (an !== 4'hF && seg !== 7'h40) bad++;
      @(negedge clk);
    end
    check("restart_busy_len", n, DW);
    check("restart_no_partial", bad, 0);
    observe_round({7'h40, 7'h40, 7'h19, 7'h24}, 4'b0000, "restart");

    // Hex load during a conversion aborts it
    load_val(16'd1234, 1'b1);
    repeat (3) @(negedge clk);
    load_val(16'hBEEF, 1'b0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    observe_round({7'h03, 7'h06, 7'h06, 7'h0E}, 4'b0000, "abort");

    // Reset in the middle of a conversion
    load_val(16'd1234, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_an", {28'd0, an}, 32'hF);
    check("midrst_seg", {25'd0, seg}, 32'h7F);
    repeat (DW + 4) @(negedge clk);
    observe_round({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, "midrst");

    // Reset wins over a simultaneous load
    load_val(16'h0777, 1'b0);
    @(negedge clk);
    reset = 1'b1; value = 16'd9876; mode = 1'b1; load = 1'b1;
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    check("rstload_busy", {31'd0, busy}, 32'd0);
    repeat (DW + 4) @(negedge clk);
    observe_round({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, "rstload");

    // Live blank_lz; mode change without load is ignored
    load_val(16'h0007, 1'b0);
    mode = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check("mode_ignored", bad, 0);
    observe_round({7'h40, 7'h40, 7'h40, 7'h78}, 4'b0000, "lz_off");
    blank_lz = 1'b1;
    dp_mask  = 4'b1001;
    observe_round({7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1001, "lz_live");

    // enable=0 blanks the anodes on the next edge
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_an", {28'd0, an}, 32'hF);
    bad = 0;
    repeat (2 * ND * DIV) begin
      @(negedge clk);
      if (an !== 4'hF) bad++;
    end
    check("dis_hold", bad, 0);
    enable = 1'b1;
    observe_round({7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1001, "reen");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
